// File: rtl/width_serializer.sv
// Buffers IN_W-bit words in a DEPTH-entry FIFO and emits each as IN_W/OUT_W OUT_W-bit beats.
// Define WIDTH_SERIALIZER_IFG_EN to force IFG_BEATS idle cycles after every frame.
module width_serializer #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 2,
    parameter int LSB_FIRST = 1,
    parameter int DEPTH     = 4,
    parameter int IFG_BEATS = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [IN_W-1:0]            s_data,
    input  logic                       s_last,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_last,
    output logic                       underrun,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int RATIO = IN_W / OUT_W;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
`ifdef WIDTH_SERIALIZER_IFG_EN
    localparam int IFG_W = (IFG_BEATS > 1) ? $clog2(IFG_BEATS) : 1;
    localparam bit IFG_OK = (IFG_BEATS >= 1);
`else
    localparam bit IFG_OK = (IFG_BEATS >= 0);
`endif

    generate
        if ((IN_W % OUT_W) != 0 || RATIO < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || !IFG_OK)
        begin : g_bad_cfg
            $error("width_serializer: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {ST_EMPTY, ST_SHIFT, ST_IFG} state_t;

    logic [IN_W:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    state_t           r_state;
    logic [IN_W-1:0]  r_word;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_frame;
    logic             r_underrun;
`ifdef WIDTH_SERIALIZER_IFG_EN
    logic [IFG_W-1:0] r_ifg_cnt;
`endif

    logic             w_push;
    logic             w_pop;
    logic             w_fifo_ne;
    logic             w_beat;
    logic             w_final;
    logic             w_to_ifg;
    logic             w_leave_ifg;
    logic [IN_W:0]    w_head;
    logic [CNT_W-1:0] w_slice_idx;
    logic [OUT_W-1:0] w_slice;

    assign s_ready   = (r_level != LVL_FULL);
    assign w_push    = s_valid && s_ready;
    assign w_fifo_ne = (r_level != '0);
    assign w_head    = r_mem[r_rd_ptr];
    assign w_beat    = (r_state == ST_SHIFT) && m_ready;
    assign w_final   = w_beat && (r_cnt == CNT_LAST);
`ifdef WIDTH_SERIALIZER_IFG_EN
    assign w_to_ifg    = w_final && r_last;
    assign w_leave_ifg = (r_state == ST_IFG) && (r_ifg_cnt == '0);
`else
    assign w_to_ifg    = 1'b0;
    assign w_leave_ifg = 1'b0;
`endif
    // The next word is pulled in on the same edge as the final beat, so frames run bubble-free.
    assign w_pop = w_fifo_ne && ((r_state == ST_EMPTY) || (w_final && !w_to_ifg) || w_leave_ifg);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_push && w_pop) r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_word     <= '0;
            r_last     <= 1'b0;
            r_cnt      <= '0;
            r_in_frame <= 1'b0;
            r_underrun <= 1'b0;
`ifdef WIDTH_SERIALIZER_IFG_EN
            r_ifg_cnt  <= '0;
`endif
        end else begin
            r_underrun <= w_final && !r_last && r_in_frame && !w_fifo_ne;
            if (w_final && r_last) r_in_frame <= 1'b0;
            if (w_pop) begin
                r_state <= ST_SHIFT;
                r_word  <= w_head[IN_W-1:0];
                r_last  <= w_head[IN_W];
                r_cnt   <= '0;
                if (!w_head[IN_W]) r_in_frame <= 1'b1;
            end else if (w_final) begin
                r_state <= w_to_ifg ? ST_IFG : ST_EMPTY;
                r_cnt   <= '0;
            end else if (w_beat) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_leave_ifg) begin
                r_state <= ST_EMPTY;
            end
`ifdef WIDTH_SERIALIZER_IFG_EN
            // Gap counter runs on cycles, not beats: m_ready has no effect while idling.
            if (w_to_ifg) begin
                r_ifg_cnt <= IFG_W'(IFG_BEATS - 1);
            end else if ((r_state == ST_IFG) && (r_ifg_cnt != '0)) begin
                r_ifg_cnt <= r_ifg_cnt - IFG_W'(1);
            end
`endif
        end
    end

    always_comb begin
        w_slice_idx = (LSB_FIRST != 0) ? r_cnt : (CNT_LAST - r_cnt);
        w_slice     = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (w_slice_idx == CNT_W'(i)) w_slice = r_word[i*OUT_W +: OUT_W];
        end
    end

    assign m_valid  = (r_state == ST_SHIFT);
    assign m_data   = m_valid ? w_slice : '0;
    assign m_last   = m_valid && r_last && (r_cnt == CNT_LAST);
    assign underrun = r_underrun;
    assign level    = r_level;

endmodule

// File: tb/tb_width_serializer.sv
// Bench for width_serializer: LSB-first and MSB-first instances share stimulus and are checked
// every cycle against a queue-based reference model, plus directed literal expectations.
module tb_width_serializer;
    localparam int IN_W      = 8;
    localparam int OUT_W     = 2;
    localparam int RATIO     = IN_W / OUT_W;
    localparam int DEPTH     = 4;
    localparam int IFG_BEATS = 12;
`ifdef WIDTH_SERIALIZER_IFG_EN
    localparam int EXP_GAP = IFG_BEATS;
`else
    localparam int EXP_GAP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       m_ready = 1'b0;
    logic [7:0] s_data = '0;

    logic       s_ready_lsb, m_valid_lsb, m_last_lsb, und_lsb;
    logic [1:0] m_data_lsb;
    logic [2:0] level_lsb;
    logic       s_ready_msb, m_valid_msb, m_last_msb, und_msb;
    logic [1:0] m_data_msb;
    logic [2:0] level_msb;

    always #5 clk = ~clk;

    width_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1), .DEPTH(DEPTH), .IFG_BEATS(IFG_BEATS)) dut_lsb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_lsb), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_lsb), .m_ready(m_ready), .m_data(m_data_lsb), .m_last(m_last_lsb),
        .underrun(und_lsb), .level(level_lsb));

    width_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(0), .DEPTH(DEPTH), .IFG_BEATS(IFG_BEATS)) dut_msb (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_msb), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid_msb), .m_ready(m_ready), .m_data(m_data_msb), .m_last(m_last_msb),
        .underrun(und_msb), .level(level_msb));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queued words, plus the list of beats still owed for the word in flight.
    typedef struct packed { logic [1:0] l; logic [1:0] m; } beat_t;
    logic [8:0] q[$];
    beat_t      st[$];
    logic       st_last = 1'b0;
    int         ifg = 0;
    logic       mdl_und = 1'b0;
    bit         started = 0;

    task automatic model_step();
        int         pre;
        bit         push;
        logic [8:0] w;
        if (rst) begin
            q.delete();
            st.delete();
            st_last = 1'b0;
            ifg     = 0;
            mdl_und = 1'b0;
            return;
        end
        pre     = q.size();
        push    = s_valid && (pre != DEPTH);
        mdl_und = 1'b0;
        if (st.size() != 0) begin
            if (m_ready) begin
                if (st.size() == 1) begin
                    if (!st_last && pre == 0) mdl_und = 1'b1;
`ifdef WIDTH_SERIALIZER_IFG_EN
                    if (st_last) ifg = IFG_BEATS;
`endif
                end
                void'(st.pop_front());
            end
        end else if (ifg > 0) begin
            ifg--;
        end
        if (st.size() == 0 && ifg == 0 && pre > 0) begin
            w       = q.pop_front();
            st_last = w[8];
            for (int k = 0; k < RATIO; k++) begin
                st.push_back('{l: 2'(w[7:0] >> (OUT_W * k)), m: 2'(w[7:0] >> (OUT_W * (RATIO - 1 - k)))});
            end
        end
        if (push) q.push_back({s_last, s_data});
    endtask

    function automatic logic [1:0] mdl_data(input bit lsb);
        if (st.size() == 0) return 2'b00;
        return lsb ? st[0].l : st[0].m;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
        started = 1;
    end

    initial forever begin
        @(negedge clk);
        if (started) begin
            chk("m_valid_lsb",  m_valid_lsb, st.size() != 0);
            chk("m_data_lsb",   m_data_lsb,  mdl_data(1));
            chk("m_last_lsb",   m_last_lsb,  st.size() == 1 && st_last);
            chk("underrun_lsb", und_lsb,     mdl_und);
            chk("level_lsb",    level_lsb,   q.size());
            chk("s_ready_lsb",  s_ready_lsb, q.size() != DEPTH);
            chk("m_valid_msb",  m_valid_msb, st.size() != 0);
            chk("m_data_msb",   m_data_msb,  mdl_data(0));
            chk("m_last_msb",   m_last_msb,  st.size() == 1 && st_last);
            chk("underrun_msb", und_msb,     mdl_und);
            chk("level_msb",    level_msb,   q.size());
            chk("s_ready_msb",  s_ready_msb, q.size() != DEPTH);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        repeat (20) tick();
    endtask

    int nv, nl, nu, fi, li, lb;
    task automatic mon_clear();
        nv = 0; nl = 0; nu = 0; fi = -1; li = -1; lb = 0;
    endtask
    task automatic mon_sample(input int i);
        if (m_valid_lsb) begin
            if (fi < 0) fi = i;
            li = i;
            nv++;
            if (m_last_lsb) begin
                nl++;
                lb = nv;
            end
        end
        if (und_lsb) nu++;
    endtask

    logic [1:0] exp_l [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [1:0] exp_m [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [7:0] w3 [3]    = '{8'h11, 8'h22, 8'h33};
    logic [7:0] bp [6]    = '{8'hA1, 8'h5E, 8'hC3, 8'h27, 8'h9B, 8'h60};
    logic [7:0] w5 [3]    = '{8'h6C, 8'h5A, 8'h96};
    int         vprob [4] = '{60, 90, 30, 80};
    int         rprob [4] = '{75, 30, 95, 100};

    initial begin
        int         acc, ml, nx, gap;
        logic [1:0] bl[$];
        logic [1:0] bm[$];
        int         last_at;

        // Reset values
        rst = 1'b1;
        tick(); tick();
        chk("rst_valid", m_valid_lsb, 0);
        chk("rst_data", m_data_lsb, 0);
        chk("rst_last", m_last_lsb, 0);
        chk("rst_underrun", und_lsb, 0);
        chk("rst_level", level_lsb, 0);
        chk("rst_s_ready", s_ready_lsb, 1);
        rst = 1'b0;

        // Bit order and first-word latency with 0xB4
        m_ready = 1'b1;
        s_valid = 1'b1; s_data = 8'hB4; s_last = 1'b1;
        tick();
        s_valid = 1'b0;
        chk("lat_idle", m_valid_lsb, 0);
        chk("lat_level", level_lsb, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("b4_valid", m_valid_lsb, 1);
            chk("b4_lsb", m_data_lsb, exp_l[i]);
            chk("b4_msb", m_data_msb, exp_m[i]);
            chk("b4_last", m_last_lsb, i == 3);
            chk("model_b4_lsb", mdl_data(1), exp_l[i]);
            chk("model_b4_msb", mdl_data(0), exp_m[i]);
            tick();
        end
        chk("b4_done", m_valid_lsb, 0);
        drain();

        // Back-to-back three-word frame
        mon_clear();
        for (int i = 0; i < 30; i++) begin
            s_valid = (i < 3);
            s_data  = (i < 3) ? w3[i] : 8'h00;
            s_last  = (i == 2);
            mon_sample(i);
            tick();
        end
        s_valid = 1'b0;
        chk("b2b_beats", nv, 12);
        chk("b2b_contig", li - fi + 1, 12);
        chk("b2b_nlast", nl, 1);
        chk("b2b_last_pos", lb, 12);
        chk("b2b_underrun", nu, 0);
        drain();

        // Backpressure until full, then release
        m_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (s_ready_lsb) acc++;
            s_valid = 1'b1; s_data = bp[i]; s_last = (i == 4);
            tick();
        end
        s_valid = 1'b0;
        chk("full_accepted", acc, 5);
        chk("full_s_ready", s_ready_lsb, 0);
        chk("full_level", level_lsb, 4);
        chk("full_valid", m_valid_lsb, 1);
        chk("full_hold_lsb", m_data_lsb, 2'b01);
        chk("full_hold_msb", m_data_msb, 2'b10);
        tick();
        chk("full_hold2_lsb", m_data_lsb, 2'b01);
        last_at = -1;
        for (int i = 0; i < 40; i++) begin
            m_ready = 1'b1;
            if (m_valid_lsb) begin
                bl.push_back(m_data_lsb);
                bm.push_back(m_data_msb);
                if (m_last_lsb) last_at = bl.size();
            end
            tick();
        end
        chk("drain_beats", bl.size(), 20);
        chk("drain_last_pos", last_at, 20);
        for (int j = 0; j < 20 && j < bl.size(); j++) begin
            chk("drain_lsb", bl[j], 2'(bp[j / 4] >> (2 * (j % 4))));
            chk("drain_msb", bm[j], 2'(bp[j / 4] >> (2 * (3 - j % 4))));
        end
        drain();

        // Underrun: lone non-last word
        s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b0;
        tick();
        s_valid = 1'b0;
        chk("ur_lat", m_valid_lsb, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("ur_beat_valid", m_valid_lsb, 1);
            chk("ur_beat_data", m_data_lsb, 2'b11);
            chk("ur_early", und_lsb, 0);
            tick();
        end
        chk("ur_pulse", und_lsb, 1);
        chk("ur_pulse_msb", und_msb, 1);
        chk("ur_idle", m_valid_lsb, 0);
        tick();
        chk("ur_pulse_end", und_lsb, 0);
        mon_clear();
        for (int i = 0; i < 12; i++) begin
            s_valid = (i == 0); s_data = 8'h00; s_last = 1'b1;
            mon_sample(i);
            tick();
        end
        s_valid = 1'b0;
        chk("ur_resume_beats", nv, 4);
        chk("ur_resume_nlast", nl, 1);
        chk("ur_resume_last_pos", lb, 4);
        chk("ur_resume_underrun", nu, 0);
        drain();

        // Reset during the second beat of a three-word frame
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = w5[i]; s_last = (i == 2);
            tick();
        end
        s_valid = 1'b0;
        chk("mid_valid", m_valid_lsb, 1);
        chk("mid_lsb", m_data_lsb, 2'b11);
        chk("mid_msb", m_data_msb, 2'b10);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", m_valid_lsb, 0);
        chk("mid_rst_level", level_lsb, 0);
        chk("mid_rst_s_ready", s_ready_lsb, 1);
        chk("mid_rst_last", m_last_lsb, 0);
        rst = 1'b0;
        s_valid = 1'b1; s_data = 8'hB4; s_last = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("restart_valid", m_valid_lsb, 1);
        chk("restart_lsb", m_data_lsb, 2'b00);
        chk("restart_msb", m_data_msb, 2'b10);
        drain();

        // Two single-word frames back to back: idle gap between them
        ml = -1; nx = -1;
        for (int i = 0; i < 40; i++) begin
            s_valid = (i < 2);
            s_data  = (i == 0) ? 8'hA5 : 8'h5A;
            s_last  = 1'b1;
            if (m_valid_lsb && ml >= 0 && nx < 0) nx = i;
            if (m_last_lsb && ml < 0) ml = i;
            tick();
        end
        s_valid = 1'b0;
        gap = (ml >= 0 && nx >= 0) ? (nx - ml - 1) : -1;
        chk("ifg_gap", gap, EXP_GAP);
        drain();

        // Randomised traffic in phases of differing fill/drain pressure
        for (int ph = 0; ph < 4; ph++) begin
            for (int c = 0; c < 1000; c++) begin
                rst     = ($urandom_range(0, 499) == 0);
                s_valid = ($urandom_range(0, 99) < vprob[ph]);
                s_data  = 8'($urandom);
                s_last  = ($urandom_range(0, 3) == 0);
                m_ready = ($urandom_range(0, 99) < rprob[ph]);
                tick();
            end
        end
        rst = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (30) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/width_serializer.md
Name: width_serializer

Overview:
- Parametrised successor to the RMII byte-to-dibit converter; sits between the Ethernet TX framer and the PHY pin driver.
- Accepts IN_W-bit words with a frame-end marker and buffers them in a DEPTH-entry FIFO.
- Emits each word as IN_W/OUT_W consecutive OUT_W-bit beats, in a selectable bit order.
- Provides input backpressure, output ready/valid, frame-end tagging and an underrun flag.

Parameters:
- IN_W, 8, input word width; must be a multiple of OUT_W; RATIO = IN_W/OUT_W must be >= 2.
- OUT_W, 2, output beat width.
- LSB_FIRST, 1, 1 = lowest slice sent first; 0 = highest slice sent first.
- DEPTH, 4, FIFO entries (power of two, >= 2), excluding the shift stage.
- IFG_BEATS, 12, idle beats forced after each frame; used only when the optional feature is compiled in.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input word valid
- s_ready  out  1  FIFO can accept a word
- s_data  in  IN_W  input word
- s_last  in  1  word is the final word of a frame
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accepts the beat
- m_data  out  OUT_W  output beat
- m_last  out  1  final beat of a frame
- underrun  out  1  one-cycle pulse: frame starved mid-transmission
- level  out  $clog2(DEPTH+1)  FIFO occupancy (excludes the shift stage)

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-high.
  - Reset clears the FIFO, shift stage, beat counter and frame/IFG state.
  - Reset values: m_valid=0, m_data=0, m_last=0, underrun=0, level=0; s_ready=1 from the first cycle after reset.
  - Reset mid-frame discards all buffered and partially sent data; no m_last is produced.
- Input:
  - A word is written when s_valid && s_ready at a rising edge.
  - s_ready = (level != DEPTH), registered-state derived, with no combinational path from m_ready.
  - Writes to a full FIFO cannot occur.
- Shift stage: holds one word, its last flag, and beat counter cnt (0..RATIO-1).
  - States: EMPTY (m_valid=0), SHIFT (m_valid=1), IFG (feature only).
  - EMPTY -> SHIFT: at the first edge where the FIFO is non-empty; pop the head word, cnt=0.
  - Beat transfer occurs on m_valid && m_ready; cnt increments.
  - m_valid, m_data and m_last hold stable while m_ready=0.
  - Beat on cnt=RATIO-1:
    - If the FIFO is non-empty, pop the next word the same edge, cnt=0, with no bubble.
    - Otherwise go to EMPTY.
  - Simultaneous push and pop at the same edge: level is unchanged; both operations are honoured.
- Latency: a word accepted at edge k into an empty FIFO with an EMPTY shift stage gives m_valid=1 after edge k+1.
- Data slice:
  - LSB_FIRST=1: m_data = word[cnt*OUT_W +: OUT_W].
  - LSB_FIRST=0: m_data = word[IN_W-1-cnt*OUT_W -: OUT_W].
  - m_data=0 when m_valid=0.
- Framing:
  - m_last = m_valid && word_last && (cnt==RATIO-1).
  - The in_frame flag sets when a non-last word loads and clears on the m_last transfer.
- Underrun:
  - Pulses high for exactly one cycle (the cycle after the edge) when the final beat of a non-last word transfers and the FIFO is empty.
  - The block then goes to EMPTY, keeps in_frame, and resumes normally when data arrives.
  - No pulse between frames.
- Buffer capacity: DEPTH+1 words total, counting the shift stage.

Optional Feature:
- Macro: WIDTH_SERIALIZER_IFG_EN.
- Defined:
  - After the m_last transfer, enter IFG; m_valid=0 for exactly IFG_BEATS cycles (counter ignores m_ready), then go to EMPTY/SHIFT per FIFO state.
  - The FIFO still accepts writes during IFG.
  - underrun is never raised in IFG.
- Undefined:
  - No IFG state; the next frame's first beat may follow m_last on the very next cycle.
  - IFG_BEATS is ignored.

Test Plan:
- Bit order:
  - Push 0xB4 with s_last=1, m_ready=1, LSB_FIRST=1 -> m_data 00,01,11,10 on 4 consecutive cycles, m_last only on the 4th.
  - With LSB_FIRST=0 -> 10,11,01,00.
- Back-to-back frame: push 0x11,0x22,0x33 (last on 0x33) with m_ready=1 -> 12 contiguous m_valid beats, one m_last on beat 12, underrun never asserted.
- Backpressure and full:
  - m_ready=0, push 6 words -> exactly 5 accepted, s_ready=0 and level=4 afterwards, m_data frozen at slice 0 of word 1.
  - Release m_ready -> all 20 beats in order.
- Underrun: push 0xFF with s_last=0, then no input -> after 4 beats underrun=1 for one cycle, m_valid=0.
  - Later push 0x00 with s_last=1 -> 4 beats with m_last, no further underrun.
- Reset mid-frame: assert rst during beat 2 of a 3-word frame -> next cycle m_valid=0, level=0, s_ready=1.
  - A new frame afterwards starts at slice 0.
- IFG (macro defined, IFG_BEATS=12): two 1-word frames pushed back-to-back -> exactly 12 idle cycles between the first frame's m_last and the second frame's first beat.
